// File: rtl/tile_addr_pkg.sv
// Shared types and constants for the tile address sequencer.
package tile_addr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

endpackage

// File: rtl/tile_addr_seq_nest_cnt.sv
// Two-level inner/outer index counter; exposes next-state indices so the
// caller can register an address derived from them in the same cycle.
module nest_cnt #(
  parameter int DIM  = 16,
  parameter int CNTW = $clog2(DIM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv_i,
  input  logic            clr_i,
  output logic [CNTW-1:0] i_nxt_o,
  output logic [CNTW-1:0] j_nxt_o,
  output logic            line_last_o,
  output logic            tile_last_o
);

  localparam logic [CNTW-1:0] LAST = CNTW'(DIM - 1);

  logic [CNTW-1:0] i_q, i_d, j_q, j_d;

  assign line_last_o = (i_q == LAST);
  assign tile_last_o = line_last_o && (j_q == LAST);

  // Clear has priority so non-power-of-two DIM never lets j overrun.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
    end else if (adv_i) begin
      if (line_last_o) begin
        i_d = '0;
        j_d = j_q + CNTW'(1);
      end else begin
        i_d = i_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i_nxt_o = i_d;
  assign j_nxt_o = j_d;

endmodule

// File: rtl/tile_addr_seq.sv
// Walks one DIM x DIM operand tile in row- or column-major order, one address
// per valid/ready handshake. TILE_ADDR_SEQ_LOOP_EN adds a 'loop' input for back-to-back tiles.
module tile_addr_seq
  import tile_addr_pkg::*;
#(
  parameter int DIM     = 16,
  parameter int ADDRLEN = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [ADDRLEN-1:0] base,
  input  logic               addr_ready,
`ifdef TILE_ADDR_SEQ_LOOP_EN
  input  logic               loop,
`endif
  output logic               addr_valid,
  output logic [ADDRLEN-1:0] addr,
  output logic               line_last,
  output logic               tile_last,
  output logic               busy,
  output logic               done
);

  localparam int CNTW = $clog2(DIM);

  state_t             state_q;
  logic               valid_q, busy_q, done_q, mode_q;
  logic [ADDRLEN-1:0] addr_q, addr_d, base_q;
  logic [CNTW-1:0]    i_d, j_d;
  logic               ll, tl, hs, loop_en;

`ifdef TILE_ADDR_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign hs = valid_q & addr_ready;

  nest_cnt #(.DIM(DIM), .CNTW(CNTW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .adv_i      (hs),
    .clr_i      (hs & tl),
    .i_nxt_o    (i_d),
    .j_nxt_o    (j_d),
    .line_last_o(ll),
    .tile_last_o(tl)
  );

  // Address for the index pair that will be current after this edge.
  assign addr_d = (mode_q == MODE_ROW)
                ? base_q + ADDRLEN'(j_d) * ADDRLEN'(DIM) + ADDRLEN'(i_d)
                : base_q + ADDRLEN'(i_d) * ADDRLEN'(DIM) + ADDRLEN'(j_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      base_q  <= '0;
      mode_q  <= MODE_ROW;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            base_q  <= base;
            mode_q  <= mode;
            addr_q  <= base;
          end
        end
        RUN: begin
          done_q <= 1'b0;
          if (hs) begin
            if (tl) begin
              done_q <= 1'b1;
              if (loop_en) begin
                addr_q <= base_q;
              end else begin
                state_q <= DONE;
                valid_q <= 1'b0;
                addr_q  <= '0;
              end
            end else begin
              addr_q <= addr_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign line_last  = valid_q & ll;
  assign tile_last  = valid_q & tl;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tile_addr_seq.sv
// Directed bench for tile_addr_seq: table of whole-tile walks plus reset and loop sequences.
module tb_tile_addr_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, mode = 1'b0, ready = 1'b0;
  logic [8:0] base = '0;
  logic       valid, line_last, tile_last, busy, done;
  logic [8:0] addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_addr_seq #(.DIM(16), .ADDRLEN(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base      (base),
    .addr_ready(ready),
`ifdef TILE_ADDR_SEQ_LOOP_EN
    .loop      (1'b0),
`endif
    .addr_valid(valid),
    .addr      (addr),
    .line_last (line_last),
    .tile_last (tile_last),
    .busy      (busy),
    .done      (done)
  );

`ifdef TILE_ADDR_SEQ_LOOP_EN
  logic       start2 = 1'b0, ready2 = 1'b0, loop2 = 1'b0;
  logic [8:0] base2 = '0;
  logic       valid2, ll2, tl2, busy2, done2;
  logic [8:0] addr2;

  tile_addr_seq #(.DIM(4), .ADDRLEN(9)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .mode      (1'b0),
    .base      (base2),
    .addr_ready(ready2),
    .loop      (loop2),
    .addr_valid(valid2),
    .addr      (addr2),
    .line_last (ll2),
    .tile_last (tl2),
    .busy      (busy2),
    .done      (done2)
  );
`endif

  typedef struct {
    logic       m;
    logic [8:0] b;
    bit         bp;
    logic [8:0] first;
    logic [8:0] last;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Walks one full 16x16 tile, checking every presented address against the model.
  task automatic run_tile(input vec_t v);
    int         k = 0, cyc = 0;
    logic [8:0] e, last_seen = '0;
    bit         rdy;
    @(negedge clk);
    start = 1'b1; mode = v.m; base = v.b; ready = 1'b0;
    @(negedge clk);
    start = 1'b0; mode = ~v.m; base = ~v.b;
    chk("first_valid", valid, 1);
    chk("first_addr", addr, v.first);
    while (k < 256 && cyc < 3000) begin
      rdy   = v.bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      ready = rdy;
      start = (k == 50);
      e = v.m ? 9'((v.b + (k % 16) * 16 + k / 16) % 512)
              : 9'((v.b + (k / 16) * 16 + k % 16) % 512);
      chk("addr", addr, e);
      chk("valid", valid, 1);
      chk("line_last", line_last, (k % 16) == 15);
      chk("tile_last", tile_last, k == 255);
      chk("done_in_run", done, 0);
      if (rdy) begin
        last_seen = addr;
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b0;
    chk("tile_complete", k, 256);
    chk("last_addr", last_seen, v.last);
    chk("done_pulse", done, 1);
    chk("valid_in_done", valid, 0);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("done_cleared", done, 0);
    chk("busy_idle", busy, 0);
    chk("addr_idle", addr, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 9'h000, 1'b0, 9'h000, 9'h0FF};
    vecs[1] = '{1'b1, 9'h100, 1'b0, 9'h100, 9'h1FF};
    vecs[2] = '{1'b0, 9'h040, 1'b1, 9'h040, 9'h13F};
    vecs[3] = '{1'b0, 9'h1F0, 1'b0, 9'h1F0, 9'h0EF};
    vecs[4] = '{1'b1, 9'h005, 1'b1, 9'h005, 9'h104};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    chk("rst_line_last", line_last, 0);
    chk("rst_tile_last", tile_last, 0);

    for (int n = 0; n < 5; n++) run_tile(vecs[n]);

    // Reset partway through a tile abandons it without a done pulse.
    begin
      int k = 0;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; base = 9'h020; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (k < 100) begin
        k++;
        @(negedge clk);
      end
      chk("pre_rst_addr", addr, 9'h020 + 9'd100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ready = 1'b0;
      chk("midrst_valid", valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_addr", addr, 0);
      @(negedge clk);
      chk("midrst_no_done", done, 0);
      chk("midrst_idle_valid", valid, 0);
      run_tile(vecs[3]);
    end

`ifdef TILE_ADDR_SEQ_LOOP_EN
    // Looping 4x4 tiles: no valid bubble, done pulses on each wrap.
    begin
      int k = 0;
      @(negedge clk);
      start2 = 1'b1; loop2 = 1'b1; base2 = 9'h030; ready2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      while (k < 48) begin
        chk("loop_valid", valid2, 1);
        chk("loop_addr", addr2, 9'(48 + k % 16));
        chk("loop_done", done2, (k > 0 && k % 16 == 0));
        chk("loop_busy", busy2, 1);
        if (k == 40) loop2 = 1'b0;
        k++;
        @(negedge clk);
      end
      ready2 = 1'b0;
      chk("loop_end_done", done2, 1);
      chk("loop_end_valid", valid2, 0);
      @(negedge clk);
      chk("loop_idle_busy", busy2, 0);
      chk("loop_idle_done", done2, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
